// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the machine-mode interrupt controller
package irq_pkg;
  typedef enum logic [1:0] {IDLE, TRAP, RET} irq_state_t;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MEIE_BIT = 11;
  localparam logic [3:0] CAUSE_EXT   = 4'd11;
  localparam logic [3:0] CAUSE_TIMER = 4'd7;
  localparam logic [1:0] MTVEC_DIRECT = 2'b00;
endpackage

// File: rtl/irq_ctrl_csr_regfile.sv
// csr_regfile: machine CSRs with read mux, write decode and trap/return side effects
module csr_regfile
  import irq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic            rd,
  input  logic            wr,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  input  logic            trap,
  input  logic            ret,
  input  logic [3:0]      code,
  input  logic [XLEN-1:0] epc,
  output logic            st_mie,
  output logic            ie_mt,
  output logic            ie_me,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);
  logic st_mpie;
  logic [XLEN-1:0] mcause, mstatus_v, mie_v, mip_v;
  localparam logic [XLEN-1:0] ALIGN = ~{{(XLEN-2){1'b0}}, 2'b11};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      ie_mt   <= 1'b0;
      ie_me   <= 1'b0;
      mtvec   <= MTVEC_RST;
      mepc    <= '0;
      mcause  <= '0;
    end else if (trap) begin
      mepc    <= epc & ALIGN;
      mcause  <= {1'b1, {(XLEN-5){1'b0}}, code};
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (ret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr) begin
      if (addr == CSR_MSTATUS) begin
        st_mie  <= wdata[MIE_BIT];
        st_mpie <= wdata[MPIE_BIT];
      end
      if (addr == CSR_MIE) begin
        ie_mt <= wdata[MTIE_BIT];
        ie_me <= wdata[MEIE_BIT];
      end
      if (addr == CSR_MTVEC)  mtvec  <= wdata;
      if (addr == CSR_MEPC)   mepc   <= wdata & ALIGN;
      if (addr == CSR_MCAUSE) mcause <= wdata;
    end
  end
  always_comb begin
    mstatus_v = '0;
    mie_v = '0;
    mip_v = '0;
    mstatus_v[MIE_BIT] = st_mie;
    mstatus_v[MPIE_BIT] = st_mpie;
    mie_v[MTIE_BIT] = ie_mt;
    mie_v[MEIE_BIT] = ie_me;
    mip_v[MTIE_BIT] = timer_irq;
    mip_v[MEIE_BIT] = ext_irq;
    rdata = !rd                  ? '0 :
            addr == CSR_MSTATUS  ? mstatus_v :
            addr == CSR_MIE      ? mie_v :
            addr == CSR_MTVEC    ? mtvec :
            addr == CSR_MEPC     ? mepc :
            addr == CSR_MCAUSE   ? mcause :
            addr == CSR_MIP      ? mip_v : '0;
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: trap/return sequencer and redirect logic beside the MW stage
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic            csr_rd,
  input  logic            csr_wr,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            is_mret,
  input  logic [XLEN-1:0] epc_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            valid,
  output logic            epc_taken,
  output logic [XLEN-1:0] pc_redirect
);
  irq_state_t state, nxt;
  logic [3:0] code_q;
  logic st_mie, ie_mt, ie_me, pend;
  logic [XLEN-1:0] mtvec, mepc, base;
  csr_regfile #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST)) u_csr (
    .clk(clk), .rst_n(rst_n), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .rd(csr_rd), .wr(csr_wr && state == IDLE), .addr(csr_addr), .wdata(csr_wdata),
    .rdata(csr_rdata), .trap(state == TRAP), .ret(state == RET), .code(code_q),
    .epc(epc_pc), .st_mie(st_mie), .ie_mt(ie_mt), .ie_me(ie_me),
    .mtvec(mtvec), .mepc(mepc)
  );
  assign pend = st_mie & ((ie_me & ext_irq) | (ie_mt & timer_irq));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      code_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == TRAP) code_q <= (ie_me & ext_irq) ? CAUSE_EXT : CAUSE_TIMER;
    end
  end
  // a live mret owns the cycle, so it also blocks trap entry
  always_comb begin
    nxt = IDLE;
    if (state == IDLE)
      nxt = (is_mret && !flush)           ? RET :
            (pend && !stall && !flush)    ? TRAP : IDLE;
  end
  always_comb begin
    base = {mtvec[XLEN-1:2], 2'b00};
    valid = state == TRAP;
    epc_taken = state != IDLE;
    pc_redirect = state == RET ? mepc :
                  state != TRAP ? '0 :
                  mtvec[1:0] == MTVEC_DIRECT ? base :
                  base + {{(XLEN-6){1'b0}}, code_q, 2'b00};
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl
module tb_irq_ctrl;
  import irq_pkg::*;
  logic clk = 0, rst_n = 0, timer_irq = 0, ext_irq = 0, csr_rd = 0, csr_wr = 0;
  logic is_mret = 0, stall = 0, flush = 0, valid, epc_taken;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, csr_rdata, epc_pc = '0, pc_redirect;
  typedef struct {string tag; logic [31:0] exp;} sb_t;
  sb_t q[$];
  int errors = 0, checks = 0;

  irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .is_mret(is_mret), .epc_pc(epc_pc), .stall(stall),
    .flush(flush), .valid(valid), .epc_taken(epc_taken), .pc_redirect(pc_redirect)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: observed %h with no expected value", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    tick();
    csr_wr = 1; csr_addr = a; csr_wdata = d;
    tick();
    csr_wr = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    tick();
    csr_rd = 1; csr_addr = a;
    sb_push(tag, exp);
    #1 sb_check(csr_rdata);
    csr_rd = 0;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1;
    sb_push("rst_valid", 0); sb_push("rst_taken", 0); sb_push("rst_redir", 0);
    #1 sb_check({31'b0, valid}); sb_check({31'b0, epc_taken}); sb_check(pc_redirect);
    rd_chk("rst_mtvec", CSR_MTVEC, 32'h100);
    rd_chk("rst_mstatus", CSR_MSTATUS, 0);
    rd_chk("rst_mepc", CSR_MEPC, 0);
    rd_chk("rst_mcause", CSR_MCAUSE, 0);
    rd_chk("unmapped", 12'h123, 0);
    // timer trap, direct mode
    wr(CSR_MIE, 32'h80); wr(CSR_MTVEC, 32'h200); wr(CSR_MSTATUS, 32'h8);
    tick(); timer_irq = 1; epc_pc = 32'h44;
    sb_push("t_pre_valid", 0);
    #1 sb_check({31'b0, valid});
    sb_push("t_valid", 1); sb_push("t_redir", 32'h200); sb_push("t_taken", 1);
    tick(); #1 sb_check({31'b0, valid}); sb_check(pc_redirect); sb_check({31'b0, epc_taken});
    timer_irq = 0;
    rd_chk("t_mepc", CSR_MEPC, 32'h44);
    rd_chk("t_mcause", CSR_MCAUSE, 32'h8000_0007);
    rd_chk("t_mstatus", CSR_MSTATUS, 32'h80);
    tick(); timer_irq = 1; sb_push("no_nest", 0);
    tick(); #1 sb_check({31'b0, valid});
    rd_chk("mip", CSR_MIP, 32'h80);
    timer_irq = 0;
    wr(CSR_MEPC, 32'h47);
    rd_chk("mepc_align", CSR_MEPC, 32'h44);
    // squashed mret, then real mret with a dropped write
    tick(); is_mret = 1; flush = 1;
    tick(); is_mret = 0; flush = 0; sb_push("mret_flush", 0);
    #1 sb_check({31'b0, epc_taken});
    tick(); is_mret = 1;
    sb_push("ret_taken", 1); sb_push("ret_redir", 32'h44); sb_push("ret_valid", 0);
    tick(); #1 sb_check({31'b0, epc_taken}); sb_check(pc_redirect); sb_check({31'b0, valid});
    is_mret = 0; csr_wr = 1; csr_addr = CSR_MTVEC; csr_wdata = 32'h300;
    tick(); csr_wr = 0;
    rd_chk("ret_mstatus", CSR_MSTATUS, 32'h88);
    rd_chk("ret_wr_drop", CSR_MTVEC, 32'h200);
    // vectored, ext beats timer
    wr(CSR_MTVEC, 32'h201); wr(CSR_MIE, 32'h880);
    tick(); ext_irq = 1; timer_irq = 1; epc_pc = 32'h80;
    sb_push("v_valid", 1); sb_push("v_redir", 32'h22C);
    tick(); #1 sb_check({31'b0, valid}); sb_check(pc_redirect);
    ext_irq = 0; timer_irq = 0; csr_wr = 1; csr_addr = CSR_MTVEC; csr_wdata = 0;
    tick(); csr_wr = 0;
    rd_chk("v_mcause", CSR_MCAUSE, 32'h8000_000B);
    rd_chk("v_mepc", CSR_MEPC, 32'h80);
    rd_chk("v_mstatus", CSR_MSTATUS, 32'h80);
    rd_chk("trap_wr_drop", CSR_MTVEC, 32'h201);
    // stall holds off the trap
    wr(CSR_MSTATUS, 32'h8);
    tick(); stall = 1; timer_irq = 1; epc_pc = 32'h10; sb_push("stall1", 0);
    tick(); #1 sb_check({31'b0, valid}); sb_push("stall2", 0);
    tick(); #1 sb_check({31'b0, valid}); stall = 0;
    sb_push("stall_valid", 1); sb_push("stall_redir", 32'h21C);
    tick(); #1 sb_check({31'b0, valid}); sb_check(pc_redirect);
    timer_irq = 0;
    rd_chk("stall_mcause", CSR_MCAUSE, 32'h8000_0007);
    rd_chk("stall_mepc", CSR_MEPC, 32'h10);
    // flush blocks entry
    wr(CSR_MSTATUS, 32'h8);
    tick(); flush = 1; timer_irq = 1; sb_push("flush_block", 0);
    tick(); #1 sb_check({31'b0, valid}); flush = 0; timer_irq = 0;
    // reset during the trap cycle
    tick(); ext_irq = 1; epc_pc = 32'h99C; sb_push("r_valid", 1);
    tick(); #1 sb_check({31'b0, valid});
    rst_n = 0;
    sb_push("r_valid_drop", 0); sb_push("r_taken_drop", 0);
    #1 sb_check({31'b0, valid}); sb_check({31'b0, epc_taken});
    csr_rd = 1; csr_addr = CSR_MEPC; sb_push("r_mepc", 0);
    #1 sb_check(csr_rdata);
    csr_addr = CSR_MCAUSE; sb_push("r_mcause", 0);
    #1 sb_check(csr_rdata);
    csr_rd = 0; ext_irq = 0;
    tick(); rst_n = 1;
    rd_chk("r_mtvec", CSR_MTVEC, 32'h100);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: observed %0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
